// File: rtl/float_to_int_stage.sv
// float_to_int_stage: converts one IEEE-754 single-precision value per
// valid/ready transaction into a signed 32-bit integer. Rounding truncates
// toward zero, out-of-range inputs saturate, and NaN maps to NAN_VALUE.
// The mantissa is aligned by an iterative shifter that moves at most
// SHIFT_STEP bits per cycle.
module float_to_int_stage #(
  parameter int unsigned SHIFT_STEP = 4,
  parameter logic [31:0] NAN_VALUE  = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_invalid,
  output logic        out_inexact
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_SHIFT,
    S_SIGN,
    S_OUT
  } state_e;

  localparam logic [4:0] STEP = 5'(SHIFT_STEP);

  state_e      state_q, state_d;
  logic [31:0] op_q, op_d;            // latched float operand
  logic [31:0] work_q, work_d;        // magnitude being aligned, or final special value
  logic [4:0]  cnt_q, cnt_d;          // remaining shift distance
  logic        left_q, left_d;        // shift direction: 1 = left
  logic        sticky_q, sticky_d;    // inexact: discarded fraction bits were nonzero
  logic        special_q, special_d;  // result already final, skip sign application
  logic        invalid_q, invalid_d;
  logic        ready_q, ready_d;
  logic [31:0] out_data_q, out_data_d;
  logic        out_invalid_q, out_invalid_d;
  logic        out_inexact_q, out_inexact_d;

  logic        sign_w;
  logic [7:0]  exp_w;
  logic [22:0] man_w;
  logic [4:0]  step_k;
  logic [31:0] lost_mask;
  logic        lost_bits;

  assign sign_w = op_q[31];
  assign exp_w  = op_q[30:23];
  assign man_w  = op_q[22:0];

  // Per-cycle shift amount and the bits a right shift would drop.
  always_comb begin
    step_k    = (cnt_q > STEP) ? STEP : cnt_q;
    lost_mask = ~(32'hFFFF_FFFF << step_k);
    lost_bits = |(work_q & lost_mask);
  end

  // Next-state and datapath update for the conversion sequence.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    work_d        = work_q;
    cnt_d         = cnt_q;
    left_d        = left_q;
    sticky_d      = sticky_q;
    special_d     = special_q;
    invalid_d     = invalid_q;
    out_data_d    = out_data_q;
    out_invalid_d = out_invalid_q;
    out_inexact_d = out_inexact_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid && ready_q) begin
          op_d    = in_data;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        work_d    = {8'h00, 1'b1, man_w};
        sticky_d  = 1'b0;
        special_d = 1'b0;
        invalid_d = 1'b0;
        left_d    = 1'b0;
        cnt_d     = '0;
        state_d   = S_SIGN;
        if (exp_w == 8'hFF) begin
          special_d = 1'b1;
          invalid_d = 1'b1;
          if (man_w != '0) begin
            work_d = NAN_VALUE;
          end else begin
            work_d = sign_w ? 32'h8000_0000 : 32'h7FFF_FFFF;
          end
        end else if (exp_w == 8'h00) begin
          special_d = 1'b1;
          work_d    = '0;
          sticky_d  = |man_w;
        end else if (exp_w < 8'd127) begin
          special_d = 1'b1;
          work_d    = '0;
          sticky_d  = 1'b1;
        end else if (exp_w >= 8'd158) begin
          // -2^31 is the only representable value at this exponent.
          special_d = 1'b1;
          if (sign_w) begin
            work_d    = 32'h8000_0000;
            invalid_d = (op_q != 32'hCF00_0000);
          end else begin
            work_d    = 32'h7FFF_FFFF;
            invalid_d = 1'b1;
          end
        end else if (exp_w <= 8'd150) begin
          cnt_d = 5'(8'd150 - exp_w);
          if (cnt_d != '0) begin
            state_d = S_SHIFT;
          end
        end else begin
          left_d  = 1'b1;
          cnt_d   = 5'(exp_w - 8'd150);
          state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (left_q) begin
          work_d = work_q << step_k;
        end else begin
          work_d   = work_q >> step_k;
          sticky_d = sticky_q | lost_bits;
        end
        cnt_d = cnt_q - step_k;
        if (cnt_d == '0) begin
          state_d = S_SIGN;
        end
      end

      S_SIGN: begin
        out_data_d    = (sign_w && !special_q) ? (~work_q + 32'd1) : work_q;
        out_invalid_d = invalid_q;
        out_inexact_d = sticky_q;
        state_d       = S_OUT;
      end

      S_OUT: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Ready is registered so it stays low for the first edge out of reset.
  assign ready_d = (state_d == S_IDLE);

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      op_q          <= '0;
      work_q        <= '0;
      cnt_q         <= '0;
      left_q        <= 1'b0;
      sticky_q      <= 1'b0;
      special_q     <= 1'b0;
      invalid_q     <= 1'b0;
      ready_q       <= 1'b0;
      out_data_q    <= '0;
      out_invalid_q <= 1'b0;
      out_inexact_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      work_q        <= work_d;
      cnt_q         <= cnt_d;
      left_q        <= left_d;
      sticky_q      <= sticky_d;
      special_q     <= special_d;
      invalid_q     <= invalid_d;
      ready_q       <= ready_d;
      out_data_q    <= out_data_d;
      out_invalid_q <= out_invalid_d;
      out_inexact_q <= out_inexact_d;
    end
  end

  assign in_ready    = ready_q;
  assign out_valid   = (state_q == S_OUT);
  assign out_data    = out_data_q;
  assign out_invalid = out_invalid_q;
  assign out_inexact = out_inexact_q;

endmodule

// File: tb/tb_float_to_int_stage.sv
// Testbench for float_to_int_stage: directed vector table, randomized
// vectors against an arithmetic reference model, and hand-written
// backpressure / reset / SHIFT_STEP=1 sequences.
module tb_float_to_int_stage;

  localparam int          STEP0 = 4;
  localparam logic [31:0] NANV  = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid, in_ready, out_valid, out_ready, out_invalid, out_inexact;
  logic [31:0] in_data, out_data;
  logic        in_valid1, in_ready1, out_valid1, out_ready1, out_invalid1, out_inexact1;
  logic [31:0] in_data1, out_data1;

  float_to_int_stage #(.SHIFT_STEP(STEP0), .NAN_VALUE(NANV)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_invalid(out_invalid), .out_inexact(out_inexact)
  );

  float_to_int_stage #(.SHIFT_STEP(1), .NAN_VALUE(NANV)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
    .out_invalid(out_invalid1), .out_inexact(out_inexact1)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference conversion from plain integer arithmetic on the float fields.
  function automatic void ref_model(input logic [31:0] f, input int step,
                                    output logic [31:0] d, output logic inv,
                                    output logic inx, output int lat);
    int     e, ee, sh;
    longint m, mag, sv;
    e   = int'(f[30:23]);
    ee  = e - 127;
    m   = longint'({1'b1, f[22:0]});
    d   = '0;
    inv = 1'b0;
    inx = 1'b0;
    lat = 2;
    if (e == 255) begin
      inv = 1'b1;
      d   = (f[22:0] != 0) ? NANV : (f[31] ? 32'h8000_0000 : 32'h7FFF_FFFF);
      return;
    end
    if (e == 0) begin
      inx = (f[22:0] != 0);
      return;
    end
    if (ee < 0) begin
      inx = 1'b1;
      return;
    end
    if (ee >= 40) begin
      mag = longint'(64'd1 << 40);
    end else if (ee <= 23) begin
      sh  = 23 - ee;
      mag = m >> sh;
      inx = ((m & ((longint'(1) << sh) - 1)) != 0);
    end else begin
      mag = m << (ee - 23);
    end
    sv = f[31] ? -mag : mag;
    if (sv > 64'sd2147483647) begin
      d = 32'h7FFF_FFFF; inv = 1'b1; inx = 1'b0;
    end else if (sv < -64'sd2147483648) begin
      d = 32'h8000_0000; inv = 1'b1; inx = 1'b0;
    end else begin
      d = sv[31:0];
    end
    if (ee <= 30) begin
      sh  = (ee <= 23) ? (23 - ee) : (ee - 23);
      lat = 2 + (sh + step - 1) / step;
    end
  endfunction

  // One transaction on the default-step DUT; holds out_ready low for
  // `stall` cycles after out_valid and checks the result stays put.
  task automatic xfer(input logic [31:0] din, input int stall, input logic [31:0] exp_d,
                      output logic [31:0] d, output logic inv, output logic inx, output int lat);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("ready_before_send", {31'b0, in_ready}, 32'd1);
    in_valid  = 1'b1;
    in_data   = din;
    out_ready = (stall == 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = $urandom;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      lat++;
      #1;
    end
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL latency_timeout: got no out_valid for %h within %0d edges", din, lat);
    end
    d   = out_data;
    inv = out_invalid;
    inx = out_inexact;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("hold_valid", {31'b0, out_valid}, 32'd1);
      check("hold_data", out_data, exp_d);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("release_valid", {31'b0, out_valid}, 32'd0);
  endtask

  typedef struct {
    logic [31:0] din;
    logic [31:0] dout;
    logic        inv;
    logic        inx;
    int          lat;
  } vec_t;

  localparam int NT = 17;
  vec_t tbl [NT];
  vec_t tbl1 [2];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] d, ed;
    logic        inv, inx, einv, einx;
    int          lat, elat, guard, stale;
    logic [31:0] f;

    tbl[0]  = '{32'h3F80_0000, 32'h0000_0001, 1'b0, 1'b0, 8};
    tbl[1]  = '{32'hC2F6_E979, 32'hFFFF_FF85, 1'b0, 1'b1, 7};
    tbl[2]  = '{32'h3F00_0000, 32'h0000_0000, 1'b0, 1'b1, 2};
    tbl[3]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 2};
    tbl[4]  = '{32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 2};
    tbl[5]  = '{32'hCF00_0000, 32'h8000_0000, 1'b0, 1'b0, 2};
    tbl[6]  = '{32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0, 1'b0, 4};
    tbl[7]  = '{32'h7FC0_0000, 32'h8000_0000, 1'b1, 1'b0, 2};
    tbl[8]  = '{32'h7F80_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 2};
    tbl[9]  = '{32'hFF80_0000, 32'h8000_0000, 1'b1, 1'b0, 2};
    tbl[10] = '{32'h4B00_0000, 32'h0080_0000, 1'b0, 1'b0, 2};
    tbl[11] = '{32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1, 2};
    tbl[12] = '{32'hCF00_0001, 32'h8000_0000, 1'b1, 1'b0, 2};
    tbl[13] = '{32'h4000_0000, 32'h0000_0002, 1'b0, 1'b0, 8};
    tbl[14] = '{32'hC049_0FDB, 32'hFFFF_FFFD, 1'b0, 1'b1, 8};
    tbl[15] = '{32'h4B7F_FFFF, 32'h00FF_FFFF, 1'b0, 1'b0, 2};
    tbl[16] = '{32'h4B80_0000, 32'h0100_0000, 1'b0, 1'b0, 3};
    tbl1[0] = '{32'h3F80_0000, 32'h0000_0001, 1'b0, 1'b0, 25};
    tbl1[1] = '{32'hC2F6_E979, 32'hFFFF_FF85, 1'b0, 1'b1, 19};

    in_valid  = 1'b0; in_data  = '0; out_ready  = 1'b1;
    in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b1;

    // Reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_flags", {30'b0, out_invalid, out_inexact}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst1_out_valid", {31'b0, out_valid1}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_ready", {31'b0, in_ready}, 32'd1);
    check("post_rst_ready1", {31'b0, in_ready1}, 32'd1);

    // Directed vector table
    for (int i = 0; i < NT; i++) begin
      xfer(tbl[i].din, i % 3, tbl[i].dout, d, inv, inx, lat);
      check($sformatf("vec%0d_data", i), d, tbl[i].dout);
      check($sformatf("vec%0d_invalid", i), {31'b0, inv}, {31'b0, tbl[i].inv});
      check($sformatf("vec%0d_inexact", i), {31'b0, inx}, {31'b0, tbl[i].inx});
      check($sformatf("vec%0d_latency", i), lat, tbl[i].lat);
    end

    // Randomized vectors against the reference model
    for (int i = 0; i < 200; i++) begin
      f[31]    = 1'($urandom_range(0, 1));
      f[22:0]  = ($urandom_range(0, 7) == 0) ? 23'h0 : 23'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        f[30:23] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
      end else begin
        f[30:23] = 8'($urandom_range(110, 165));
      end
      ref_model(f, STEP0, ed, einv, einx, elat);
      xfer(f, int'($urandom_range(0, 2)), ed, d, inv, inx, lat);
      check($sformatf("rnd_data_%h", f), d, ed);
      check($sformatf("rnd_invalid_%h", f), {31'b0, inv}, {31'b0, einv});
      check($sformatf("rnd_inexact_%h", f), {31'b0, inx}, {31'b0, einx});
      check($sformatf("rnd_latency_%h", f), lat, elat);
    end

    // Backpressure: second operand held on the input while the first waits
    @(negedge clk);
    check("bp_ready_idle", {31'b0, in_ready}, 32'd1);
    in_valid  = 1'b1;
    in_data   = 32'h3F80_0000;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_data = 32'h4000_0000;
    guard = 0;
    while (!out_valid && guard < 50) begin
      @(posedge clk);
      guard++;
      #1;
    end
    check("bp_first_valid", {31'b0, out_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_data", out_data, 32'd1);
      check("bp_hold_valid", {31'b0, out_valid}, 32'd1);
      check("bp_busy_ready", {31'b0, in_ready}, 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_valid", {31'b0, out_valid}, 32'd0);
    check("bp_ready_next", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 50) begin
      @(posedge clk);
      guard++;
      #1;
    end
    check("bp_second_valid", {31'b0, out_valid}, 32'd1);
    check("bp_second_data", out_data, 32'd2);
    check("bp_second_latency", guard, 32'd8);
    @(posedge clk);
    #1;
    check("bp_second_release", {31'b0, out_valid}, 32'd0);

    // Asynchronous reset during the third shift cycle of 1.0
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 32'h3F80_0000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_out_data", out_data, 32'd0);
    check("midrst_in_ready", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_ready_after", {31'b0, in_ready}, 32'd1);
    stale = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (out_valid) stale++;
    end
    check("midrst_no_stale", stale, 32'd0);

    // SHIFT_STEP = 1 instance
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("s1_ready", {31'b0, in_ready1}, 32'd1);
      in_valid1 = 1'b1;
      in_data1  = tbl1[i].din;
      @(posedge clk);
      #1;
      in_valid1 = 1'b0;
      lat = 0;
      while (!out_valid1 && lat < 60) begin
        @(posedge clk);
        lat++;
        #1;
      end
      check($sformatf("s1_vec%0d_valid", i), {31'b0, out_valid1}, 32'd1);
      check($sformatf("s1_vec%0d_latency", i), lat, tbl1[i].lat);
      check($sformatf("s1_vec%0d_data", i), out_data1, tbl1[i].dout);
      check($sformatf("s1_vec%0d_inexact", i), {31'b0, out_inexact1}, {31'b0, tbl1[i].inx});
      @(posedge clk);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
